// File: rtl/move_pulse_gen.sv
// Button conditioning for the moving-square sprite: synchronise, debounce, resolve
// opposing directions, and emit frame-aligned bursts of direction strobes.
module move_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int FRAMES_PER_STEP = 1,
   parameter int SPEED           = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic frame_tick,
   input  logic btn_left,
   input  logic btn_right,
   input  logic btn_up,
   input  logic btn_down,
   output logic left,
   output logic right,
   output logic up,
   output logic down,
   output logic busy
);

   localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int FC_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

   localparam logic [DB_W-1:0] DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_LAST    = FC_W'(FRAMES_PER_STEP - 1);
   localparam logic [7:0]      BURST_LOAD = 8'(SPEED);

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_U = 2;
   localparam int BTN_D = 3;

   typedef struct packed {
      logic left;
      logic right;
      logic up;
      logic down;
   } dir_t;

   logic [3:0]      raw;
   logic [3:0]      sync1;
   logic [3:0]      sync2;
   logic [3:0]      stable;
   logic [DB_W-1:0] db_cnt [4];

   logic [FC_W-1:0] frame_cnt;
   logic            step_event;
   logic [7:0]      burst_cnt;
   logic            burst_active;

   dir_t resolved;
   dir_t dir_q;

   assign raw = {btn_down, btn_up, btn_right, btn_left};

   // Two-flop synchroniser followed by an independent debouncer per button.
   // NOTE: every register in this file uses non-blocking assignment so all flops
   // sample the pre-edge values; blocking here would collapse sync1/sync2 into one stage.
   // NOTE: reset is synchronous; the small debounce counter array is ordinary flops
   // and is cleared with the rest of the state rather than left uninitialised.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sync1  <= '0;
         sync2  <= '0;
         stable <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == stable[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               stable[i] <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // NOTE: default assigned first so no path through this block can infer a latch.
   always_comb begin
      resolved       = '0;
      resolved.left  = stable[BTN_L] & ~stable[BTN_R];
      resolved.right = stable[BTN_R] & ~stable[BTN_L];
      resolved.up    = stable[BTN_U] & ~stable[BTN_D];
      resolved.down  = stable[BTN_D] & ~stable[BTN_U];
   end

   assign step_event = frame_tick && (frame_cnt == FC_LAST);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         frame_cnt <= '0;
      end else if (frame_tick) begin
         frame_cnt <= (frame_cnt == FC_LAST) ? '0 : frame_cnt + FC_W'(1);
      end
   end

   // A step event always wins over a burst in progress: reload and re-latch.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         burst_cnt <= '0;
         dir_q     <= '0;
      end else if (step_event) begin
         dir_q     <= resolved;
         burst_cnt <= (resolved != '0) ? BURST_LOAD : 8'd0;
      end else if (burst_cnt != 8'd0) begin
         burst_cnt <= burst_cnt - 8'd1;
      end
   end

   assign burst_active = (burst_cnt != 8'd0);

   // Strobes depend only on flops, never on the raw buttons.
   assign left  = burst_active & dir_q.left;
   assign right = burst_active & dir_q.right;
   assign up    = burst_active & dir_q.up;
   assign down  = burst_active & dir_q.down;
   assign busy  = burst_active;

endmodule

// File: doc/move_pulse_gen.md
Name: move_pulse_gen

Overview:
- Upstream input-conditioning stage for the moving-square sprite.
- Takes the four raw push-buttons, synchronises and debounces them, and resolves opposing directions.
- Converts held buttons into bursts of direction strobes (left/right/up/down), one burst per movement step, aligned to a once-per-frame tick from the VGA timing generator.
- The sprite block moves one pixel per clock while a strobe is high, so burst length sets pixels moved per step. Bursts land in vertical blanking, and the sprite never tears mid-frame.

Parameters:
- DEBOUNCE_CYCLES, 250000: consecutive clocks a synchronised button must differ from its debounced state before that state flips. Legal range ≥1.
- FRAMES_PER_STEP, 1: frame ticks per movement step. Legal range ≥1.
- SPEED, 2: clocks the strobe is held per step, i.e. pixels moved per step. Legal range 1..255.

Ports:
- clk, input, 1: pixel clock; the single clock domain.
- rstn, input, 1: reset, synchronous, active-low.
- frame_tick, input, 1: one-clock pulse from the timing generator at the first blanking line (h_count==0, v_count==480).
- btn_left, input, 1: raw button, asynchronous, active-high.
- btn_right, input, 1: raw button, asynchronous, active-high.
- btn_up, input, 1: raw button, asynchronous, active-high.
- btn_down, input, 1: raw button, asynchronous, active-high.
- left, output, 1: move-left strobe to the sprite block.
- right, output, 1: move-right strobe to the sprite block.
- up, output, 1: move-up strobe to the sprite block.
- down, output, 1: move-down strobe to the sprite block.
- busy, output, 1: high while a burst is in progress.

Behaviour:
- Reset:
  - Only clock and reset are fixed: one clock (clk); reset rstn is synchronous, active-low.
  - rstn==0 at a clk edge clears all state.
  - Reset values: synchroniser flops 0, debounced states 0, debounce counters 0, frame counter 0, burst counter 0, latched direction 0.
  - Outputs left/right/up/down/busy are 0 in the cycle after the reset edge.
  - Reset mid-burst aborts the burst immediately.
- Synchroniser:
  - Each button passes through 2 flops (s1, s2) before any other logic.
- Debounce (independent per button):
  - If s2 == stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s2 != stable, stable <= s2 and the counter <= 0.
  - Net effect: a raw change held steady is reflected in stable after exactly 2+DEBOUNCE_CYCLES clock edges.
  - Any bounce back to the old level before then restarts the count.
- Direction resolve, combinational on the stable states:
  - dx_left = L & ~R; dx_right = R & ~L.
  - dy_up = U & ~D; dy_down = D & ~U.
  - Both buttons of an axis pressed gives no motion on that axis. The other axis is unaffected.
- Step scheduler:
  - The frame counter (wraps at FRAMES_PER_STEP-1) advances only on frame_tick.
  - A step event is frame_tick && frame_counter == FRAMES_PER_STEP-1.
  - On a step event, in the same edge: the four resolved direction bits are latched and the burst counter is loaded with SPEED.
  - If all resolved bits are 0, the burst counter is loaded with 0 and no burst occurs.
- Burst:
  - While burst counter != 0: outputs = latched direction bits, busy = 1, and the counter decrements each clock.
  - First strobe cycle is the cycle after the step-event edge (latency 1). Last strobe cycle is SPEED cycles later.
  - Outputs are registered, with no combinational path from the buttons.
  - Button changes during a burst do not alter the burst in progress.
- Simultaneous / overlapping events:
  - A step event while a burst is active reloads the counter and re-latches direction; the new burst wins.
  - A frame_tick that is not a step event only advances the frame counter.
- Exclusivity:
  - left and right are never both 1.
  - up and down are never both 1.
  - Diagonal combinations (e.g. left+up) are permitted.

Test Plan (DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=2, SPEED=3, frame_tick every 100 clks):
- Reset: drive rstn=0 for 3 clks with all buttons high and ticks running -> all outputs 0 for every cycle of reset and the cycle after release. No strobe before 2+4 edges post-release plus the next step event.
- Clean press: btn_right=1 held -> debounced 6 edges after press. At the first step event (every 2nd tick), right=1 for exactly 3 consecutive cycles starting 1 cycle after the tick, busy matching. No strobe on the intervening tick. Exactly 3 right-strobe cycles per 200 clks.
- Bounce: btn_up toggles 1,0,1,0 every 2 clks, then stays 0 -> debounced state never changes. up stays 0 through 4 step events.
- Opposing/diagonal: btn_left=btn_right=1 and btn_down=1 -> at each step event down=1 for 3 cycles while left=right=0. Release btn_right -> left joins the strobes from the next step event.
- Mid-burst: reset asserted on the 2nd strobe cycle -> outputs 0 from the next cycle. Separately, btn_left released during a burst -> the burst still completes its 3 cycles, and the next step event produces no strobe (6+ clks after release).
- Exclusivity/latency checker: random button stimulus over 20 frames -> assertions hold (never left&right, never up&down). Every strobe run is exactly 3 cycles and begins exactly 1 cycle after a step-event tick.
